ifetch_buffer: RTL and testbench



---
 rtl/ifetch_buffer.sv | 147 ++++++++++++++
 tb/tb_ifetch_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: issues sequential word fetches under a credit limit,
// buffers in-order responses in a prefetch FIFO, and hands {pc, instr} to decode.
module ifetch_buffer #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            branch_v_i,
    input  logic [XLEN-1:0] branch_adr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_adr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_v_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic            req_q, req_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic            instr_v_q, instr_v_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];

    logic            grant;
    logic            drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target;
    logic [SW-1:0]   credit;
    entry_t          head;

    // Next-state for counters, FIFO, fetch address and the registered head/request.
    always_comb begin
        grant     = req_q & imem_gnt_i;
        drop      = imem_rvalid_i & (disc_q != '0);
        push      = imem_rvalid_i & (disc_q == '0) & ~branch_v_i;
        pop       = instr_v_q & instr_ready_i & ~branch_v_i;
        target    = branch_adr_i & ~XLEN'(3);

        adr_d     = adr_q;
        disc_d    = disc_q;
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        out_d     = out_q + CW'(grant) - CW'(imem_rvalid_i);

        if (branch_v_i) begin
            // Flush: everything still in flight after this edge is dropped on return.
            cnt_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            disc_d    = out_d;
            adr_d     = target;
            resp_pc_d = target;
        end else begin
            if (grant) begin
                adr_d = adr_q + XLEN'(4);
            end
            if (drop) begin
                disc_d = disc_q - CW'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: resp_pc_q, instr: imem_rdata_i};
                wr_ptr_d        = wr_ptr_q + PW'(1);
                resp_pc_d       = resp_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        credit    = SW'(cnt_d) + SW'(out_d) - SW'(disc_d);
        req_d     = (credit < SW'(DEPTH)) && (out_d < CW'(DEPTH));

        head      = mem_d[rd_ptr_d];
        instr_v_d = (cnt_d != '0);
        instr_d   = instr_v_d ? head.instr : instr_q;
        pc_d      = instr_v_d ? head.pc    : pc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= 1'b0;
            adr_q     <= RESET_VECTOR;
            instr_v_q <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            disc_q    <= '0;
            resp_pc_q <= RESET_VECTOR;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_q     <= '{default: '0};
        end else begin
            req_q     <= req_d;
            adr_q     <= adr_d;
            instr_v_q <= instr_v_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            resp_pc_q <= resp_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end

    assign imem_req_o = req_q;
    assign imem_adr_o = adr_q;
    assign instr_v_o  = instr_v_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;

`ifndef SYNTHESIS
    a_out_max: assert property (@(posedge clk) disable iff (!reset_n) out_q <= CW'(DEPTH));
    a_disc_le_out: assert property (@(posedge clk) disable iff (!reset_n) disc_q <= out_q);
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: in-order memory model with per-request epochs and a
// scoreboard of {pc, instr} expected at decode; table of redirect targets plus corner sequences.
module tb_ifetch_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic            clk;
    logic            reset_n;
    logic            branch_v_i;
    logic [XLEN-1:0] branch_adr_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_adr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_v_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic            instr_ready_i;

    ifetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_v_i    (branch_v_i),
        .branch_adr_i  (branch_adr_i),
        .imem_req_o    (imem_req_o),
        .imem_adr_o    (imem_adr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_v_o     (instr_v_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] br_adr;
        bit          b2b;
        logic [31:0] exp_adr;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       memq[$];
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          grants   = 0;
    int          gnt_pct  = 100;
    int          rdy_pct  = 100;
    int          lat_max  = 1;
    bit          rv_en    = 1'b1;
    bit          br       = 1'b0;
    logic [31:0] br_adr   = '0;
    logic [31:0] exp_adr  = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_adr = '0;
    bit          got      = 1'b0;
    logic [31:0] got_pc   = '0;
    bit          last_rv  = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: called at a negedge, samples outputs, drives inputs, advances to next negedge.
    task automatic step();
        bit    g;
        bit    r;
        bit    rv;
        bit    deliver;
        mreq_t m;
        exp_t  e;
        g       = ($urandom_range(99) < gnt_pct);
        r       = ($urandom_range(99) < rdy_pct);
        rv      = 1'b0;
        deliver = 1'b0;
        imem_rdata_i = '0;
        if (rv_en && memq.size() > 0 && memq[0].due <= cyc) begin
            m  = memq.pop_front();
            rv = 1'b1;
            imem_rdata_i = mem_data(m.adr);
            deliver = (m.epoch == epoch) && !br;
        end
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        instr_ready_i = r;
        branch_v_i    = br;
        branch_adr_i  = br_adr;
        last_rv       = rv;

        if (prev_stall) begin
            chk("req_held", 32'(imem_req_o), 32'd1);
            chk("adr_held", imem_adr_o, prev_adr);
        end
        prev_stall = imem_req_o && !g && !br;
        prev_adr   = imem_adr_o;

        if (imem_req_o && g) begin
            chk("req_adr", imem_adr_o, exp_adr);
            memq.push_back('{adr: imem_adr_o, epoch: epoch, due: cyc + int'($urandom_range(lat_max, 1))});
            exp_adr = exp_adr + 32'd4;
            grants++;
            chk("outstanding_le_depth", 32'(memq.size() <= DEPTH), 32'd1);
        end

        got = 1'b0;
        if (instr_v_o && r && !br) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr actual_pc=%h expected=none (cycle %0d)", pc_o, cyc);
            end else begin
                e = sb.pop_front();
                chk("pc", pc_o, e.pc);
                chk("instr", instr_o, e.data);
            end
            got    = 1'b1;
            got_pc = pc_o;
        end

        if (deliver) begin
            e.pc   = m.adr;
            e.data = mem_data(m.adr);
            sb.push_back(e);
        end

        if (br) begin
            epoch++;
            exp_adr = br_adr & ~32'd3;
            sb.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        branch_v_i    = 1'b0;
        branch_adr_i  = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_adr", imem_adr_o, 32'h0);
        chk("rst_instr_v", 32'(instr_v_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        memq.delete();
        sb.delete();
        exp_adr    = '0;
        epoch++;
        prev_stall = 1'b0;
        grants     = 0;
        br         = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_first(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (got) begin
                seen = 1'b1;
                chk(name, got_pc, exp_pc);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=none expected=%h", name, exp_pc);
        end
    endtask

    initial begin
        vec_t        vecs[5];
        int          pops;
        logic [31:0] a;

        vecs[0] = '{br_adr: 32'h0000_1002, b2b: 1'b0, exp_adr: 32'h0000_1000, exp_pc: 32'h0000_1000};
        vecs[1] = '{br_adr: 32'h2000_0007, b2b: 1'b1, exp_adr: 32'h2000_0004, exp_pc: 32'h2000_0004};
        vecs[2] = '{br_adr: 32'hFFFF_FFFE, b2b: 1'b0, exp_adr: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC};
        vecs[3] = '{br_adr: 32'h0000_0041, b2b: 1'b1, exp_adr: 32'h0000_0040, exp_pc: 32'h0000_0040};
        vecs[4] = '{br_adr: 32'h8000_0010, b2b: 1'b0, exp_adr: 32'h8000_0010, exp_pc: 32'h8000_0010};

        reset_n       = 1'b1;
        branch_v_i    = 1'b0;
        branch_adr_i  = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        @(negedge clk);

        // Streaming from reset: first request in first cycle, first instr two cycles after grant.
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_max = 1; rv_en = 1'b1;
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_adr", imem_adr_o, 32'h0);
        step();
        chk("lat_v_c1", 32'(instr_v_o), 32'd0);
        step();
        chk("lat_v_c2", 32'(instr_v_o), 32'd1);
        chk("lat_pc_c2", pc_o, 32'h0);
        pops = 0;
        repeat (20) begin
            step();
            pops += int'(got);
        end
        chk("throughput", 32'(pops), 32'd20);

        // Decode stalled: credit limit stops issue at DEPTH.
        do_reset();
        gnt_pct = 100; rdy_pct = 0; lat_max = 1; rv_en = 1'b1;
        repeat (10) step();
        chk("stall_grants", 32'(grants), 32'd4);
        chk("stall_req_off", 32'(imem_req_o), 32'd0);
        chk("stall_head_v", 32'(instr_v_o), 32'd1);
        chk("stall_head_pc", pc_o, 32'h0);
        rdy_pct = 100;
        step();
        rdy_pct = 0;
        chk("refill_req", 32'(imem_req_o), 32'd1);
        chk("refill_adr", imem_adr_o, 32'h10);
        chk("refill_head_pc", pc_o, 32'h4);
        step();
        rdy_pct = 100;
        repeat (10) step();

        // Grant withheld: address held, then advances by one word.
        repeat (3) step();
        a = imem_adr_o;
        chk("gnt0_req", 32'(imem_req_o), 32'd1);
        gnt_pct = 0;
        repeat (3) step();
        chk("gnt0_adr", imem_adr_o, a);
        gnt_pct = 100;
        step();
        chk("gnt1_adr", imem_adr_o, a + 32'd4);
        repeat (5) step();

        // Redirect with entries buffered and requests outstanding.
        do_reset();
        gnt_pct = 100; rdy_pct = 0; lat_max = 1; rv_en = 1'b1;
        repeat (3) step();
        rv_en = 1'b0;
        step();
        chk("pre_br_v", 32'(instr_v_o), 32'd1);
        br = 1'b1; br_adr = 32'h0000_1002;
        step();
        br = 1'b0;
        chk("br_v_clear", 32'(instr_v_o), 32'd0);
        chk("br_adr", imem_adr_o, 32'h0000_1000);
        rv_en = 1'b1; rdy_pct = 100;
        wait_first("br_first_pc", 32'h0000_1000);
        repeat (8) step();

        // Redirect coinciding with rvalid, grant and pop.
        gnt_pct = 100; rdy_pct = 100; lat_max = 1;
        repeat (4) step();
        chk("coinc_req", 32'(imem_req_o), 32'd1);
        chk("coinc_v", 32'(instr_v_o), 32'd1);
        br = 1'b1; br_adr = 32'h0000_3000;
        step();
        br = 1'b0;
        chk("coinc_rvalid", 32'(last_rv), 32'd1);
        chk("coinc_v_clear", 32'(instr_v_o), 32'd0);
        wait_first("coinc_first_pc", 32'h0000_3000);
        repeat (8) step();

        // Table of redirect targets under random grant/ready/latency.
        gnt_pct = 70; rdy_pct = 60; lat_max = 3;
        for (int i = 0; i < 5; i++) begin
            repeat (6) step();
            if (vecs[i].b2b) begin
                br = 1'b1; br_adr = 32'hDEAD_0000;
                step();
            end
            br = 1'b1; br_adr = vecs[i].br_adr;
            step();
            br = 1'b0;
            chk("tbl_v_clear", 32'(instr_v_o), 32'd0);
            chk("tbl_adr", imem_adr_o, vecs[i].exp_adr);
            wait_first("tbl_first_pc", vecs[i].exp_pc);
            repeat (12) step();
        end

        // Reset pulsed mid-stream.
        gnt_pct = 100; rdy_pct = 50; lat_max = 2;
        repeat (7) step();
        do_reset();
        gnt_pct = 100; rdy_pct = 100; lat_max = 1;
        chk("post_rst_adr", imem_adr_o, 32'h0);
        wait_first("post_rst_pc", 32'h0);
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
